fsa_line_edge: RTL and testbench



---
 rtl/fsa_line_edge.sv | 198 +++++++++++++++++++
 tb/tb_fsa_line_edge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsa_line_edge.sv
// rtl/fsa_line_edge.sv - per-line multi-channel edge scanner with a 2-entry result FIFO
// Optional FSA_EDGE_COUNT_EN adds a saturating qualifying-pixel count to every channel field.
module fsa_line_edge #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WW      = 12,
  parameter int C_IMG_HW      = 12,
  parameter int C_CH          = 2,
`ifdef FSA_EDGE_COUNT_EN
  localparam int F            = 3 * C_IMG_WW + 1,
`else
  localparam int F            = 2 * C_IMG_WW + 1,
`endif
  localparam int DW           = C_CH * F + C_IMG_HW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [C_IMG_WW-1:0]           width,
  input  logic [C_IMG_HW-1:0]           height,
  input  logic [C_CH*C_PIXEL_WIDTH-1:0] ref_data,
  input  logic [C_IMG_WW-1:0]           win_l,
  input  logic [C_IMG_WW-1:0]           win_r,
  input  logic                          s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0]      s_axis_tdata,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DW-1:0]                 m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
);

  logic                          cfg_loaded;
  logic [C_IMG_WW-1:0]           sh_width;
  logic [C_IMG_HW-1:0]           sh_height;
  logic [C_CH*C_PIXEL_WIDTH-1:0] sh_ref;
  logic [C_IMG_WW-1:0]           sh_win_l;
  logic [C_IMG_WW-1:0]           sh_win_r;

  logic [C_IMG_WW-1:0]           col;
  logic [C_IMG_HW-1:0]           row;

  logic [C_CH*C_IMG_WW-1:0]      lft_q, lft_n;
  logic [C_CH*C_IMG_WW-1:0]      rt_q, rt_n;
  logic [C_CH-1:0]               found_q, found_n;
`ifdef FSA_EDGE_COUNT_EN
  logic [C_CH*C_IMG_WW-1:0]      cnt_q, cnt_n;
`endif
  logic [C_CH-1:0]               qual;

  logic                          accept;
  logic                          load;
  logic                          push;
  logic                          pop;
  logic [C_IMG_WW-1:0]           e_width;
  logic [C_IMG_HW-1:0]           e_height;
  logic [C_CH*C_PIXEL_WIDTH-1:0] e_ref;
  logic [C_IMG_WW-1:0]           e_win_l;
  logic [C_IMG_WW-1:0]           e_win_r;
  logic [C_IMG_WW-1:0]           e_col;
  logic [C_IMG_HW-1:0]           e_row;
  logic                          in_win;
  logic                          len_err;
  logic                          res_first;
  logic                          res_last;
  logic [DW-1:0]                 res_data;

  logic [DW+1:0]                 fifo_mem [2];
  logic                          wr_ptr;
  logic                          rd_ptr;
  logic [1:0]                    count;
  logic [1:0]                    count_n;
  logic                          ready_q;

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (count != 2'd0);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_mem[rd_ptr];

  // A config-loading beat is judged with the freshly sampled inputs, not the old shadow.
  always_comb begin
    accept   = s_axis_tvalid & ready_q;
    load     = accept & (s_axis_tuser | ~cfg_loaded);
    e_width  = load ? width    : sh_width;
    e_height = load ? height   : sh_height;
    e_ref    = load ? ref_data : sh_ref;
    e_win_l  = load ? win_l    : sh_win_l;
    e_win_r  = load ? win_r    : sh_win_r;
    e_col    = s_axis_tuser ? '0 : col;
    e_row    = s_axis_tuser ? '0 : row;
    in_win   = (e_col >= e_win_l) && (e_col <= e_win_r);

    res_data = '0;
    lft_n    = s_axis_tuser ? '0 : lft_q;
    rt_n     = s_axis_tuser ? '0 : rt_q;
    found_n  = s_axis_tuser ? '0 : found_q;
`ifdef FSA_EDGE_COUNT_EN
    cnt_n    = s_axis_tuser ? '0 : cnt_q;
`endif
    for (int k = 0; k < C_CH; k++) begin
      qual[k] = in_win && (s_axis_tdata < e_ref[k*C_PIXEL_WIDTH +: C_PIXEL_WIDTH]);
      if (qual[k]) begin
        if (!found_n[k]) begin
          lft_n[k*C_IMG_WW +: C_IMG_WW] = e_col;
        end
        rt_n[k*C_IMG_WW +: C_IMG_WW] = e_col;
        found_n[k] = 1'b1;
`ifdef FSA_EDGE_COUNT_EN
        if (cnt_n[k*C_IMG_WW +: C_IMG_WW] != {C_IMG_WW{1'b1}}) begin
          cnt_n[k*C_IMG_WW +: C_IMG_WW] = cnt_n[k*C_IMG_WW +: C_IMG_WW] + 1'b1;
        end
`endif
      end
      res_data[k*F +: C_IMG_WW]            = lft_n[k*C_IMG_WW +: C_IMG_WW];
      res_data[k*F + C_IMG_WW +: C_IMG_WW] = rt_n[k*C_IMG_WW +: C_IMG_WW];
      res_data[k*F + 2*C_IMG_WW]           = found_n[k];
`ifdef FSA_EDGE_COUNT_EN
      res_data[k*F + 2*C_IMG_WW + 1 +: C_IMG_WW] = cnt_n[k*C_IMG_WW +: C_IMG_WW];
`endif
    end

    len_err   = ({1'b0, e_col} + 1'b1) != {1'b0, e_width};
    res_first = (e_row == '0);
    res_last  = (e_row == e_height - 1'b1);
    res_data[C_CH*F +: C_IMG_HW] = e_row;
    res_data[DW-1]               = len_err;

    push    = accept & s_axis_tlast;
    pop     = m_axis_tvalid & m_axis_tready;
    count_n = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_loaded  <= 1'b0;
      sh_width    <= '0;
      sh_height   <= '0;
      sh_ref      <= '0;
      sh_win_l    <= '0;
      sh_win_r    <= '0;
      col         <= '0;
      row         <= '0;
      lft_q       <= '0;
      rt_q        <= '0;
      found_q     <= '0;
`ifdef FSA_EDGE_COUNT_EN
      cnt_q       <= '0;
`endif
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      ready_q     <= 1'b0;
    end else begin
      if (load) begin
        cfg_loaded <= 1'b1;
        sh_width   <= width;
        sh_height  <= height;
        sh_ref     <= ref_data;
        sh_win_l   <= win_l;
        sh_win_r   <= win_r;
      end
      if (accept) begin
        if (s_axis_tlast) begin
          col     <= '0;
          row     <= res_last ? '0 : e_row + 1'b1;
          lft_q   <= '0;
          rt_q    <= '0;
          found_q <= '0;
`ifdef FSA_EDGE_COUNT_EN
          cnt_q   <= '0;
`endif
        end else begin
          // A line with no tlast parks at the last column instead of wrapping.
          col     <= (e_col == {C_IMG_WW{1'b1}}) ? e_col : e_col + 1'b1;
          row     <= e_row;
          lft_q   <= lft_n;
          rt_q    <= rt_n;
          found_q <= found_n;
`ifdef FSA_EDGE_COUNT_EN
          cnt_q   <= cnt_n;
`endif
        end
      end
      if (push) begin
        fifo_mem[wr_ptr] <= {res_first, res_last, res_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count   <= count_n;
      ready_q <= (count_n != 2'd2);
    end
  end

endmodule

// File: tb/tb_fsa_line_edge.sv
// tb/tb_fsa_line_edge.sv - randomized self-checking bench for fsa_line_edge
module tb_fsa_line_edge;
  localparam int WW = 12;
  localparam int HW = 12;
  localparam int PW = 8;
  localparam int CH = 2;
`ifdef FSA_EDGE_COUNT_EN
  localparam int F  = 3 * WW + 1;
`else
  localparam int F  = 2 * WW + 1;
`endif
  localparam int DW = CH * F + HW + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WW-1:0]    width = '0;
  logic [HW-1:0]    height = '0;
  logic [CH*PW-1:0] ref_data = '0;
  logic [WW-1:0]    win_l = '0;
  logic [WW-1:0]    win_r = '0;
  logic             s_axis_tvalid = 1'b0;
  logic [PW-1:0]    s_axis_tdata = '0;
  logic             s_axis_tuser = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tready;
  logic             m_axis_tvalid;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tuser;
  logic             m_axis_tlast;
  logic             m_axis_tready = 1'b1;

  always #5 clk = ~clk;

  fsa_line_edge #(
    .C_PIXEL_WIDTH(PW), .C_IMG_WW(WW), .C_IMG_HW(HW), .C_CH(CH)
  ) dut (
    .clk(clk), .reset(reset), .width(width), .height(height), .ref_data(ref_data),
    .win_l(win_l), .win_r(win_r),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  typedef struct {
    logic [7:0] pix;
    bit         user;
    bit         last;
    int         w, h, wl, wr, r0, r1;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    bit            u;
    bit            l;
  } res_t;

  beat_t bq[$];
  res_t  exp_q[$];
  res_t  got_q[$];
  res_t  saved_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  function automatic logic [7:0] pat(input int r, input int c);
    if (((r >= 5 && r <= 7) || (r >= 10 && r <= 15)) && (c <= 17 || c >= 23)) return 8'd10;
    return 8'(128 + c);
  endfunction

  // Reference result for one line: scan the pixels, keep first/last/count of qualifiers.
  function automatic logic [DW-1:0] model_line(input logic [7:0] px[$], input int row,
                                               input int w, input int wl, input int wr,
                                               input int r0, input int r1);
    logic [DW-1:0] d;
    int lo, hi, n, rk;
    d = '0;
    for (int k = 0; k < CH; k++) begin
      rk = (k == 0) ? r0 : r1;
      lo = -1;
      hi = -1;
      n  = 0;
      for (int c = 0; c < px.size(); c++) begin
        if (c >= wl && c <= wr && int'(px[c]) < rk) begin
          if (lo < 0) lo = c;
          hi = c;
          n++;
        end
      end
      if (lo >= 0) begin
        d[k*F +: WW]      = WW'(lo);
        d[k*F + WW +: WW] = WW'(hi);
        d[k*F + 2*WW]     = 1'b1;
      end
`ifdef FSA_EDGE_COUNT_EN
      d[k*F + 2*WW + 1 +: WW] = WW'((n > 4095) ? 4095 : n);
`endif
    end
    d[CH*F +: HW] = HW'(row);
    d[DW-1]       = (px.size() != w);
    return d;
  endfunction

  task automatic add_frame(input int mode, input int w, input int h, input int wl, input int wr,
                           input int r0, input int r1, input int short_row, input int short_len,
                           input int chg_row, input int chg_r0);
    logic [7:0] px[$];
    beat_t b;
    res_t e;
    int len;
    for (int r = 0; r < h; r++) begin
      len = (r == short_row) ? short_len : w;
      px.delete();
      for (int c = 0; c < len; c++) px.push_back(mode == 0 ? pat(r, c) : 8'($urandom_range(0, 255)));
      for (int c = 0; c < len; c++) begin
        b.pix  = px[c];
        b.user = (r == 0 && c == 0);
        b.last = (c == len - 1);
        b.w = w; b.h = h; b.wl = wl; b.wr = wr; b.r1 = r1;
        b.r0 = (chg_row >= 0 && r >= chg_row) ? chg_r0 : r0;
        bq.push_back(b);
      end
      e.d = model_line(px, r, w, wl, wr, r0, r1);
      e.u = (r == 0);
      e.l = (r == h - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_beat(input int idx, input bit rnd);
    if (idx < bq.size()) begin
      s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata  = bq[idx].pix;
      s_axis_tuser  = bq[idx].user;
      s_axis_tlast  = bq[idx].last;
      width         = WW'(bq[idx].w);
      height        = HW'(bq[idx].h);
      win_l         = WW'(bq[idx].wl);
      win_r         = WW'(bq[idx].wr);
      ref_data      = {8'(bq[idx].r1), 8'(bq[idx].r0)};
    end else begin
      s_axis_tvalid = 1'b0;
    end
    m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Drives bq, collects results into got_q and tracks FIFO occupancy from observed handshakes.
  task automatic run_stream(input bit rnd, input int stop_at);
    int idx, occ, budget;
    bit hold_v, push, pop;
    res_t hold, r;
    idx = 0; occ = 0; budget = 0; hold_v = 0;
    drive_beat(idx, rnd);
    forever begin
      @(negedge clk);
      if (occ == 2) begin
        n_checks++;
        if (s_axis_tready !== 1'b0) $display("FAIL fifo_full_ready: s_axis_tready=%b required 0", s_axis_tready);
        else n_pass++;
      end
      if (hold_v) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold.d || m_axis_tuser !== hold.u || m_axis_tlast !== hold.l)
          $display("FAIL hold_stable: got v=%b %h/%b/%b required v=1 %h/%b/%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, hold.d, hold.u, hold.l);
        else n_pass++;
      end
      r.d = m_axis_tdata; r.u = m_axis_tuser; r.l = m_axis_tlast;
      pop = m_axis_tvalid && m_axis_tready;
      if (pop) got_q.push_back(r);
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold = r;
      push = 0;
      if (s_axis_tvalid && s_axis_tready) begin
        push = s_axis_tlast;
        idx++;
      end
      occ = occ + int'(push) - int'(pop);
      budget++;
      @(posedge clk);
      #1;
      if ((stop_at >= 0 && idx >= stop_at) || (stop_at < 0 && idx >= bq.size() && occ == 0)) begin
        s_axis_tvalid = 1'b0;
        break;
      end
      if (budget > 20000) begin
        n_checks++;
        $display("FAIL stream_timeout: sent %0d beats required %0d", idx, bq.size());
        s_axis_tvalid = 1'b0;
        break;
      end
      drive_beat(idx, rnd);
    end
  endtask

  task automatic clear_q();
    bq.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_axis_tready !== 1'b0) $display("FAIL reset_s_tready: got %b required 0", s_axis_tready); else n_pass++;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0)
      $display("FAIL reset_m_ctrl: got v=%b u=%b l=%b required 0", m_axis_tvalid, m_axis_tuser, m_axis_tlast);
    else n_pass++;
    n_checks++;
    if (m_axis_tdata !== '0) $display("FAIL reset_m_tdata: got %h required 0", m_axis_tdata); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", s_axis_tready); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_threshold();
    logic [DW-1:0] d0, d5;
    clear_q();
    add_frame(0, 40, 20, 0, 39, 128, 140, -1, 0, -1, 0);
    run_stream(0, -1);
    n_checks++;
    if (got_q.size() != 20) $display("FAIL thr_count: got %0d results required 20", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l)
        $display("FAIL thr_line%0d: got %h/%b/%b required %h/%b/%b", i, got_q[i].d, got_q[i].u, got_q[i].l,
                 exp_q[i].d, exp_q[i].u, exp_q[i].l);
      else n_pass++;
    end
    if (got_q.size() == 20) begin
      d0 = got_q[0].d;
      d5 = got_q[5].d;
      n_checks++;
      if (d0[2*WW] !== 1'b0) $display("FAIL thr_row0_ch0_found: got %b required 0", d0[2*WW]); else n_pass++;
      n_checks++;
      if (d0[F +: WW] !== 12'd0 || d0[F + WW +: WW] !== 12'd11 || d0[F + 2*WW] !== 1'b1)
        $display("FAIL thr_row0_ch1: got lft=%0d rt=%0d found=%b required 0/11/1", d0[F +: WW], d0[F + WW +: WW], d0[F + 2*WW]);
      else n_pass++;
      n_checks++;
      if (d5[0 +: WW] !== 12'd0 || d5[WW +: WW] !== 12'd39)
        $display("FAIL thr_row5_ch0: got lft=%0d rt=%0d required 0/39", d5[0 +: WW], d5[WW +: WW]);
      else n_pass++;
      n_checks++;
      if (got_q[0].u !== 1'b1 || got_q[19].l !== 1'b1 || got_q[18].l !== 1'b0)
        $display("FAIL thr_frame_marks: got u0=%b l18=%b l19=%b required 1/0/1", got_q[0].u, got_q[18].l, got_q[19].l);
      else n_pass++;
`ifdef FSA_EDGE_COUNT_EN
      n_checks++;
      if (d5[2*WW + 1 +: WW] !== 12'd35 || d0[F + 2*WW + 1 +: WW] !== 12'd12)
        $display("FAIL thr_counts: got row5 ch0=%0d row0 ch1=%0d required 35/12", d5[2*WW + 1 +: WW], d0[F + 2*WW + 1 +: WW]);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_window();
    logic [DW-1:0] d;
    clear_q();
    add_frame(0, 40, 20, 18, 22, 128, 140, -1, 0, -1, 0);
    add_frame(0, 40, 20, 30, 20, 128, 140, -1, 0, -1, 0);
    run_stream(0, -1);
    n_checks++;
    if (got_q.size() != 40) $display("FAIL win_count: got %0d results required 40", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l)
        $display("FAIL win_line%0d: got %h/%b/%b required %h/%b/%b", i, got_q[i].d, got_q[i].u, got_q[i].l,
                 exp_q[i].d, exp_q[i].u, exp_q[i].l);
      else n_pass++;
    end
    if (got_q.size() > 5) begin
      d = got_q[5].d;
      n_checks++;
      if (d[0 +: F] !== '0) $display("FAIL win_row5_ch0: got field %h required 0", d[0 +: F]); else n_pass++;
    end
    for (int i = 20; i < got_q.size(); i++) begin
      d = got_q[i].d;
      n_checks++;
      if (d[2*WW] !== 1'b0 || d[F + 2*WW] !== 1'b0)
        $display("FAIL win_inverted_line%0d: got found=%b%b required 00", i - 20, d[F + 2*WW], d[2*WW]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    add_frame(0, 40, 20, 0, 39, 128, 140, -1, 0, -1, 0);
    add_frame(1, 24, 6, 5, 34, $urandom_range(30, 220), $urandom_range(30, 220), -1, 0, -1, 0);
    add_frame(0, 40, 20, 10, 30, 100, 200, -1, 0, -1, 0);
    run_stream(0, -1);
    saved_q = got_q;
    got_q.delete();
    run_stream(1, -1);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d results required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (saved_q.size() != exp_q.size()) $display("FAIL bp_ref_count: got %0d results required %0d", saved_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l)
        $display("FAIL bp_line%0d: got %h/%b/%b required %h/%b/%b", i, got_q[i].d, got_q[i].u, got_q[i].l,
                 exp_q[i].d, exp_q[i].u, exp_q[i].l);
      else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < saved_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== saved_q[i].d || got_q[i].u !== saved_q[i].u || got_q[i].l !== saved_q[i].l)
        $display("FAIL bp_vs_ready_run%0d: got %h required %h", i, got_q[i].d, saved_q[i].d);
      else n_pass++;
    end
  endtask

  task automatic test_short_line();
    logic [DW-1:0] d;
    clear_q();
    add_frame(1, 40, 20, 0, 39, 128, 140, 3, 30, 8, 20);
    add_frame(1, 40, 20, 0, 39, 20, 140, -1, 0, -1, 0);
    run_stream(0, -1);
    n_checks++;
    if (got_q.size() != 40) $display("FAIL short_count: got %0d results required 40", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l)
        $display("FAIL short_line%0d: got %h/%b/%b required %h/%b/%b", i, got_q[i].d, got_q[i].u, got_q[i].l,
                 exp_q[i].d, exp_q[i].u, exp_q[i].l);
      else n_pass++;
    end
    if (got_q.size() > 4) begin
      d = got_q[3].d;
      n_checks++;
      if (d[DW-1] !== 1'b1) $display("FAIL short_len_err: got %b required 1", d[DW-1]); else n_pass++;
      d = got_q[2].d;
      n_checks++;
      if (d[DW-1] !== 1'b0) $display("FAIL full_len_err: got %b required 0", d[DW-1]); else n_pass++;
      d = got_q[4].d;
      n_checks++;
      if (d[CH*F +: HW] !== 12'd4) $display("FAIL short_row_advance: got %0d required 4", d[CH*F +: HW]); else n_pass++;
    end
  endtask

  task automatic test_reset_midline();
    logic [DW-1:0] d;
    clear_q();
    add_frame(0, 40, 20, 0, 39, 128, 140, -1, 0, -1, 0);
    run_stream(0, 7 * 40 + 16);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || s_axis_tready !== 1'b0)
      $display("FAIL midreset_outputs: got v=%b d=%h rdy=%b required 0/0/0", m_axis_tvalid, m_axis_tdata, s_axis_tready);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 7) $display("FAIL midreset_count: got %0d results required 7", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < 7; i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d) $display("FAIL midreset_line%0d: got %h required %h", i, got_q[i].d, exp_q[i].d);
      else n_pass++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    clear_q();
    add_frame(0, 40, 20, 0, 39, 128, 140, -1, 0, -1, 0);
    run_stream(0, -1);
    n_checks++;
    if (got_q.size() != 20) $display("FAIL post_reset_count: got %0d results required 20", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i].d || got_q[i].u !== exp_q[i].u || got_q[i].l !== exp_q[i].l)
        $display("FAIL post_reset_line%0d: got %h/%b/%b required %h/%b/%b", i, got_q[i].d, got_q[i].u, got_q[i].l,
                 exp_q[i].d, exp_q[i].u, exp_q[i].l);
      else n_pass++;
    end
    if (got_q.size() > 0) begin
      d = got_q[0].d;
      n_checks++;
      if (got_q[0].u !== 1'b1 || d[CH*F +: HW] !== 12'd0)
        $display("FAIL post_reset_row0: got u=%b row=%0d required 1/0", got_q[0].u, d[CH*F +: HW]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_window();
    test_back_to_back();
    test_short_line();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
